// File: rtl/awb_stats_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : awb_stats_pkg
//  Description : Shared types and width helpers for the AWB statistics
//                collector: FSM state encoding, RGB pixel layout and the
//                derived pixel-count / channel-sum widths.
//  Revision    : 1.0  initial release
// ============================================================================
package awb_stats_pkg;

    // Collector control states.
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        DRAIN    = 2'd2,
        PUBLISH  = 2'd3
    } fsm_e;

    // Component width of the default 8-bit pixel layout.
    localparam int PX_W = 8;

    // One pixel as it sits in a lane of the RGB bus: b in the MSBs, r in the LSBs.
    typedef struct packed {
        logic [PX_W-1:0] b;
        logic [PX_W-1:0] g;
        logic [PX_W-1:0] r;
    } rgb_px_t;

    // Width able to hold a count of every pixel in a maximum-size frame.
    function automatic int cnt_w_f(input int hres, input int vres);
        return $clog2(hres * vres + 1);
    endfunction

    // Per-channel sum width: a full frame of saturated pixels never overflows.
    function automatic int sum_w_f(input int pw, input int hres, input int vres);
        return pw + cnt_w_f(hres, vres);
    endfunction

endpackage
`default_nettype wire

// File: rtl/awb_stats_lane_sum.sv
`default_nettype none
// ============================================================================
//  Module      : awb_stats_lane_sum
//  Description : First pipeline stage for one colour channel. Adds the
//                components of all lanes whose mask bit is set and
//                registers the result.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                i_mask     - per-lane include mask
//                i_comp     - lane k component at [k*PW +: PW]
//                o_sum      - registered masked lane sum
//  Revision    : 1.0  initial release
// ============================================================================
module awb_stats_lane_sum #(
    parameter  int PW   = 8,
    parameter  int PCNT = 2,
    localparam int LS_W = PW + $clog2(PCNT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PCNT-1:0]   i_mask,
    input  logic [PCNT*PW-1:0] i_comp,
    output logic [LS_W-1:0]   o_sum
);

    logic [LS_W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < PCNT; k++) begin
            if (i_mask[k]) begin
                w_sum = w_sum + LS_W'(i_comp[k*PW +: PW]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sum <= '0;
        end else begin
            o_sum <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/awb_stats.sv
`default_nettype none
// ============================================================================
//  Module      : awb_stats
//  Description : Per-frame white-balance statistics collector. Sums R, G, B
//                and counts pixels inside a programmable ROI, publishing the
//                totals with a one-cycle o_stats_valid pulse at each vsync
//                rising edge (3 cycles after vsync is first sampled high).
//  Ports       : i_pclk, i_rst          - pixel clock, sync active-high reset
//                i_vsync/i_hsync/i_de   - video timing (i_hsync unused)
//                i_valid, i_rgb         - beat qualifier and PCNT-lane pixels
//                i_roi_x0/x1/y0/y1      - inclusive ROI bounds (per frame)
//                o_sum_r/g/b, o_pix_cnt - last published totals
//                o_clip_cnt             - last published clipped-pixel count
//                o_stats_valid          - one-cycle publish strobe
//  Config      : AWB_STATS_CLIP_EXCL_EN - exclude ROI pixels with any
//                saturated component from the sums and count them instead.
//  Revision    : 1.0  initial release
// ============================================================================
module awb_stats
    import awb_stats_pkg::*;
#(
    parameter  int PW       = 8,
    parameter  int PCNT     = 2,
    parameter  int MAX_HRES = 3840,
    parameter  int MAX_VRES = 2160,
    localparam int X_W      = $clog2(MAX_HRES),
    localparam int Y_W      = $clog2(MAX_VRES),
    localparam int CNT_W    = cnt_w_f(MAX_HRES, MAX_VRES),
    localparam int SUM_W    = sum_w_f(PW, MAX_HRES, MAX_VRES)
) (
    input  logic                   i_pclk,
    input  logic                   i_rst,
    input  logic                   i_vsync,
    input  logic                   i_hsync,
    input  logic                   i_de,
    input  logic                   i_valid,
    input  logic [PW*PCNT*3-1:0]   i_rgb,
    input  logic [X_W-1:0]         i_roi_x0,
    input  logic [X_W-1:0]         i_roi_x1,
    input  logic [Y_W-1:0]         i_roi_y0,
    input  logic [Y_W-1:0]         i_roi_y1,
    output logic [SUM_W-1:0]       o_sum_r,
    output logic [SUM_W-1:0]       o_sum_g,
    output logic [SUM_W-1:0]       o_sum_b,
    output logic [CNT_W-1:0]       o_pix_cnt,
    output logic [CNT_W-1:0]       o_clip_cnt,
    output logic                   o_stats_valid
);

    localparam int LS_W = PW + $clog2(PCNT) + 1;
    localparam int PC_W = $clog2(PCNT + 1);

    logic w_unused_hsync;
    assign w_unused_hsync = i_hsync;

    // ---------------------------------------------------------------- timing
    logic            r_vs_d, r_de_d;
    logic [X_W-1:0]  r_x_cnt, r_x0, r_x1;
    logic [Y_W-1:0]  r_y_cnt, r_y0, r_y1;
    logic            w_vs_rise, w_de_fall, w_beat, w_row_in;

    assign w_vs_rise = i_vsync & ~r_vs_d;
    assign w_de_fall = r_de_d & ~i_de;
    assign w_beat    = i_de & i_valid & ~i_vsync;
    assign w_row_in  = (r_y_cnt >= r_y0) && (r_y_cnt <= r_y1);

    // ROI shadows are loaded only at frame start so mid-frame writes wait a frame.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_vs_d  <= 1'b0;
            r_de_d  <= 1'b0;
            r_x_cnt <= '0;
            r_y_cnt <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
        end else begin
            r_vs_d <= i_vsync;
            r_de_d <= i_de;
            if (w_vs_rise) begin
                r_x_cnt <= '0;
                r_y_cnt <= '0;
                r_x0    <= i_roi_x0;
                r_x1    <= i_roi_x1;
                r_y0    <= i_roi_y0;
                r_y1    <= i_roi_y1;
            end else if (w_de_fall) begin
                r_x_cnt <= '0;
                r_y_cnt <= r_y_cnt + 1'b1;
            end else if (w_beat) begin
                r_x_cnt <= r_x_cnt + X_W'(PCNT);
            end
        end
    end

    // ------------------------------------------------------- lane masking (S1)
    logic [PCNT-1:0]    w_incl, w_sum_mask;
    logic [PCNT*PW-1:0] w_r, w_g, w_b;

    for (genvar k = 0; k < PCNT; k++) begin : g_lane
        logic [X_W:0] w_col;
        assign w_col = {1'b0, r_x_cnt} + (X_W+1)'(k);
        assign w_incl[k] = w_beat && w_row_in &&
                           (w_col >= {1'b0, r_x0}) && (w_col <= {1'b0, r_x1});
        assign w_r[k*PW +: PW] = i_rgb[k*3*PW        +: PW];
        assign w_g[k*PW +: PW] = i_rgb[k*3*PW + PW   +: PW];
        assign w_b[k*PW +: PW] = i_rgb[k*3*PW + 2*PW +: PW];
    end

`ifdef AWB_STATS_CLIP_EXCL_EN
    logic [PCNT-1:0] w_clip;
    for (genvar k = 0; k < PCNT; k++) begin : g_clip
        assign w_clip[k] = w_incl[k] && ((w_r[k*PW +: PW] == {PW{1'b1}}) ||
                                         (w_g[k*PW +: PW] == {PW{1'b1}}) ||
                                         (w_b[k*PW +: PW] == {PW{1'b1}}));
    end
    assign w_sum_mask = w_incl & ~w_clip;
`else
    assign w_sum_mask = w_incl;
`endif

    logic [PC_W-1:0] w_pix_n, r_s1_pix;
    always_comb begin
        w_pix_n = '0;
        for (int k = 0; k < PCNT; k++) begin
            w_pix_n = w_pix_n + PC_W'(w_sum_mask[k]);
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_s1_pix <= '0;
        end else begin
            r_s1_pix <= w_pix_n;
        end
    end

    logic [LS_W-1:0] w_s1_r, w_s1_g, w_s1_b;

    awb_stats_lane_sum #(.PW(PW), .PCNT(PCNT)) u_sum_r (
        .clk(i_pclk), .rst(i_rst), .i_mask(w_sum_mask), .i_comp(w_r), .o_sum(w_s1_r));
    awb_stats_lane_sum #(.PW(PW), .PCNT(PCNT)) u_sum_g (
        .clk(i_pclk), .rst(i_rst), .i_mask(w_sum_mask), .i_comp(w_g), .o_sum(w_s1_g));
    awb_stats_lane_sum #(.PW(PW), .PCNT(PCNT)) u_sum_b (
        .clk(i_pclk), .rst(i_rst), .i_mask(w_sum_mask), .i_comp(w_b), .o_sum(w_s1_b));

    // ------------------------------------------------------------------- FSM
    fsm_e r_state, w_state_nx;
    logic r_drain, w_drain_nx;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_state <= WAIT_SOF;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_drain <= w_drain_nx;
        end
    end

    // Two DRAIN cycles let the last pre-vsync beat clear S1 and S2 before publish.
    always_comb begin
        w_state_nx = r_state;
        w_drain_nx = 1'b0;
        case (r_state)
            WAIT_SOF: if (w_vs_rise) w_state_nx = ACCUM;
            ACCUM:    if (w_vs_rise) w_state_nx = DRAIN;
            DRAIN: begin
                if (r_drain) begin
                    w_state_nx = PUBLISH;
                end else begin
                    w_drain_nx = 1'b1;
                end
            end
            PUBLISH:  w_state_nx = ACCUM;
            default:  w_state_nx = WAIT_SOF;
        endcase
    end

    // ---------------------------------------------------- accumulators (S2)
    // Held at zero until the first frame start so a partial frame is discarded.
    // On PUBLISH the accumulators restart from the beat arriving that cycle.
    logic             w_acc_clr;
    logic [SUM_W-1:0] r_acc_r, r_acc_g, r_acc_b;
    logic [CNT_W-1:0] r_acc_pix;

    assign w_acc_clr = (r_state == PUBLISH);

    always_ff @(posedge i_pclk) begin
        if (i_rst || r_state == WAIT_SOF) begin
            r_acc_r   <= '0;
            r_acc_g   <= '0;
            r_acc_b   <= '0;
            r_acc_pix <= '0;
        end else begin
            r_acc_r   <= (w_acc_clr ? '0 : r_acc_r)   + SUM_W'(w_s1_r);
            r_acc_g   <= (w_acc_clr ? '0 : r_acc_g)   + SUM_W'(w_s1_g);
            r_acc_b   <= (w_acc_clr ? '0 : r_acc_b)   + SUM_W'(w_s1_b);
            r_acc_pix <= (w_acc_clr ? '0 : r_acc_pix) + CNT_W'(r_s1_pix);
        end
    end

    // --------------------------------------------------------------- outputs
    logic [SUM_W-1:0] r_out_r, r_out_g, r_out_b;
    logic [CNT_W-1:0] r_out_pix;
    logic             r_valid;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_out_r   <= '0;
            r_out_g   <= '0;
            r_out_b   <= '0;
            r_out_pix <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_acc_clr;
            if (w_acc_clr) begin
                r_out_r   <= r_acc_r;
                r_out_g   <= r_acc_g;
                r_out_b   <= r_acc_b;
                r_out_pix <= r_acc_pix;
            end
        end
    end

    assign o_sum_r       = r_out_r;
    assign o_sum_g       = r_out_g;
    assign o_sum_b       = r_out_b;
    assign o_pix_cnt     = r_out_pix;
    assign o_stats_valid = r_valid;

`ifdef AWB_STATS_CLIP_EXCL_EN
    logic [PC_W-1:0]  w_clip_n, r_s1_clip;
    logic [CNT_W-1:0] r_acc_clip, r_out_clip;

    always_comb begin
        w_clip_n = '0;
        for (int k = 0; k < PCNT; k++) begin
            w_clip_n = w_clip_n + PC_W'(w_clip[k]);
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            r_s1_clip  <= '0;
            r_out_clip <= '0;
        end else begin
            r_s1_clip <= w_clip_n;
            if (w_acc_clr) begin
                r_out_clip <= r_acc_clip;
            end
        end
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst || r_state == WAIT_SOF) begin
            r_acc_clip <= '0;
        end else begin
            r_acc_clip <= (w_acc_clr ? '0 : r_acc_clip) + CNT_W'(r_s1_clip);
        end
    end

    assign o_clip_cnt = r_out_clip;
`else
    assign o_clip_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_awb_stats.sv
`default_nettype none
// ============================================================================
//  Module      : tb_awb_stats
//  Description : Self-checking bench for awb_stats. Frames are described in a
//                table; each publish expectation is queued with its required
//                strobe cycle when the closing vsync is driven and compared
//                when o_stats_valid fires. Hand-written sequences cover the
//                mid-frame reset and mid-frame ROI change.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_awb_stats;
    import awb_stats_pkg::*;

    localparam int PW       = 8;
    localparam int PCNT     = 2;
    localparam int MAX_HRES = 3840;
    localparam int MAX_VRES = 2160;
    localparam int X_W      = $clog2(MAX_HRES);
    localparam int Y_W      = $clog2(MAX_VRES);
    localparam int CNT_W    = $clog2(MAX_HRES * MAX_VRES + 1);
    localparam int SUM_W    = PW + CNT_W;

    logic                 i_pclk;
    logic                 i_rst;
    logic                 i_vsync;
    logic                 i_hsync;
    logic                 i_de;
    logic                 i_valid;
    logic [PW*PCNT*3-1:0] i_rgb;
    logic [X_W-1:0]       i_roi_x0, i_roi_x1;
    logic [Y_W-1:0]       i_roi_y0, i_roi_y1;
    logic [SUM_W-1:0]     o_sum_r, o_sum_g, o_sum_b;
    logic [CNT_W-1:0]     o_pix_cnt, o_clip_cnt;
    logic                 o_stats_valid;

    awb_stats #(.PW(PW), .PCNT(PCNT), .MAX_HRES(MAX_HRES), .MAX_VRES(MAX_VRES)) dut (
        .i_pclk        (i_pclk),
        .i_rst         (i_rst),
        .i_vsync       (i_vsync),
        .i_hsync       (i_hsync),
        .i_de          (i_de),
        .i_valid       (i_valid),
        .i_rgb         (i_rgb),
        .i_roi_x0      (i_roi_x0),
        .i_roi_x1      (i_roi_x1),
        .i_roi_y0      (i_roi_y0),
        .i_roi_y1      (i_roi_y1),
        .o_sum_r       (o_sum_r),
        .o_sum_g       (o_sum_g),
        .o_sum_b       (o_sum_b),
        .o_pix_cnt     (o_pix_cnt),
        .o_clip_cnt    (o_clip_cnt),
        .o_stats_valid (o_stats_valid)
    );

    initial i_pclk = 1'b0;
    always #5 i_pclk = ~i_pclk;

    longint cyc = 0;
    always @(posedge i_pclk) cyc <= cyc + 1;

    typedef struct {
        longint pix;
        longint r;
        longint g;
        longint b;
        longint clip;
    } exp_t;

    typedef struct {
        exp_t   e;
        longint cyc;
    } pend_t;

    typedef struct {
        int   w;
        int   h;
        int   pat;
        bit   gaps;
        bit   dirty;
        int   x0;
        int   x1;
        int   y0;
        int   y1;
        exp_t e;
    } vec_t;

    pend_t q[$];
    vec_t  vecs[6];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_pclk);
    endtask

    task automatic set_roi(input int x0, input int x1, input int y0, input int y1);
        i_roi_x0 = X_W'(x0);
        i_roi_x1 = X_W'(x1);
        i_roi_y0 = Y_W'(y0);
        i_roi_y1 = Y_W'(y1);
    endtask

    // pat 0: flat R=0x10 G=0x20 B=0x30; pat 1: R=column; pat 2: flat, G=0xFF on even columns
    function automatic rgb_px_t px(input int col, input int pat);
        rgb_px_t p;
        p.r = 8'h10;
        p.g = 8'h20;
        p.b = 8'h30;
        if (pat == 1) begin
            p.r = col[7:0];
            p.g = 8'h00;
            p.b = 8'h00;
        end
        if (pat == 2 && (col % 2) == 0) p.g = 8'hFF;
        return p;
    endfunction

    task automatic drive_frame(input int w, input int h, input int pat, input bit gaps,
                               input int lead, input int chg_line);
        i_vsync = 1'b0;
        if (lead > 0) begin
            i_de    = 1'b0;
            i_valid = 1'b0;
            i_rgb   = '0;
        end
        repeat (lead) tick();
        for (int y = 0; y < h; y++) begin
            if (y == chg_line) begin
                i_roi_y0 = Y_W'(300);
                i_roi_y1 = Y_W'(10);
            end
            for (int b = 0; b < w / PCNT; b++) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    i_de    = 1'b1;
                    i_valid = 1'b0;
                    i_rgb   = '1;
                    tick();
                end
                i_de    = 1'b1;
                i_valid = 1'b1;
                i_rgb   = {px(b*PCNT + 1, pat), px(b*PCNT, pat)};
                tick();
            end
            i_de    = 1'b0;
            i_valid = 1'b0;
            i_rgb   = '0;
            tick();
            tick();
        end
    endtask

    // Pulse vsync for 4 cycles; the strobe must appear 3 cycles after the
    // first posedge that samples vsync high.
    task automatic vsync_pulse(input bit push, input exp_t e, input bit dirty);
        pend_t p;
        i_vsync = 1'b1;
        i_de    = dirty;
        i_valid = dirty;
        if (dirty) i_rgb = '1;
        else       i_rgb = '0;
        if (push) begin
            p.e   = e;
            p.cyc = cyc + 4;
            q.push_back(p);
        end
        repeat (4) tick();
        i_vsync = 1'b0;
        if (!dirty) begin
            i_de    = 1'b0;
            i_valid = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sum_r"}, o_sum_r, 0);
        check({tag, "_sum_g"}, o_sum_g, 0);
        check({tag, "_sum_b"}, o_sum_b, 0);
        check({tag, "_pix_cnt"}, o_pix_cnt, 0);
        check({tag, "_clip_cnt"}, o_clip_cnt, 0);
        check({tag, "_valid"}, o_stats_valid, 0);
    endtask

    // Publish monitor
    initial begin
        pend_t p;
        forever begin
            @(negedge i_pclk);
            if (o_stats_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: strobe at cycle %0d with none expected", cyc);
                end else begin
                    p = q.pop_front();
                    check("pulse_cycle", cyc, p.cyc);
                    check("pix_cnt", o_pix_cnt, p.e.pix);
                    check("sum_r", o_sum_r, p.e.r);
                    check("sum_g", o_sum_g, p.e.g);
                    check("sum_b", o_sum_b, p.e.b);
                    check("clip_cnt", o_clip_cnt, p.e.clip);
                end
            end
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t z;
        z = '{0, 0, 0, 0, 0};

        vecs[0] = '{480, 270, 0, 1'b0, 1'b0, 0, 479, 0, 269, '{129600, 2073600, 4147200, 6220800, 0}};
        vecs[1] = '{64, 12, 1, 1'b0, 1'b0, 16, 31, 0, 9, '{160, 3760, 0, 0, 0}};
        vecs[2] = '{64, 12, 1, 1'b1, 1'b0, 16, 31, 0, 9, '{160, 3760, 0, 0, 0}};
        vecs[3] = '{64, 12, 0, 1'b0, 1'b0, 1, 62, 1, 10, '{620, 9920, 19840, 29760, 0}};
`ifdef AWB_STATS_CLIP_EXCL_EN
        vecs[4] = '{128, 10, 2, 1'b0, 1'b0, 0, 127, 0, 9, '{640, 10240, 20480, 30720, 640}};
`else
        vecs[4] = '{128, 10, 2, 1'b0, 1'b0, 0, 127, 0, 9, '{1280, 20480, 183680, 61440, 0}};
`endif
        vecs[5] = '{64, 12, 0, 1'b0, 1'b1, 0, 63, 0, 11, '{768, 12288, 24576, 36864, 0}};

        i_rst   = 1'b1;
        i_vsync = 1'b0;
        i_hsync = 1'b0;
        i_de    = 1'b0;
        i_valid = 1'b0;
        i_rgb   = '0;
        set_roi(0, 63, 0, 11);
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check_zero("reset");

        // Partial frame after reset: must be discarded, no strobe at first vsync
        drive_frame(64, 3, 0, 1'b0, 2, -1);

        for (int i = 0; i < 6; i++) begin
            set_roi(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
            if (i == 0) vsync_pulse(1'b0, z, vecs[i].dirty);
            else        vsync_pulse(1'b1, vecs[i-1].e, vecs[i].dirty);
            drive_frame(vecs[i].w, vecs[i].h, vecs[i].pat, vecs[i].gaps,
                        vecs[i].dirty ? 0 : 2, -1);
        end
        set_roi(0, 63, 0, 11);
        vsync_pulse(1'b1, vecs[5].e, 1'b0);

        // Mid-frame reset: outputs clear at once, next vsync gives no strobe
        drive_frame(64, 3, 0, 1'b0, 2, -1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_zero("midrst");
        drive_frame(64, 5, 0, 1'b0, 0, -1);
        vsync_pulse(1'b0, z, 1'b0);
        drive_frame(64, 12, 0, 1'b0, 2, -1);
        vsync_pulse(1'b1, vecs[5].e, 1'b0);

        // Empty ROI written mid-frame: current frame intact, next frame zero
        drive_frame(64, 12, 0, 1'b0, 2, 5);
        vsync_pulse(1'b1, vecs[5].e, 1'b0);
        drive_frame(64, 12, 0, 1'b0, 2, -1);
        set_roi(0, 63, 0, 11);
        vsync_pulse(1'b1, z, 1'b0);

        repeat (10) tick();
        check("pending_pulses", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
